// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames, LSB first, fed from a small valid/ready FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [15:0]                      prescale,
  input  logic [DATA_WIDTH-1:0]            tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic                             txd,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             overflow_error
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BIT_W = $clog2(DATA_WIDTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [15:0]             plat_q, plat_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    txd_q, txd_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
  logic                    parity_q, parity_d;
`endif
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    ready_q, ready_d;
  logic                    ovf_q, ovf_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic                    push, pop, last;

  always_comb begin
    push     = tx_valid && ready_q;
    pop      = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    plat_d   = plat_q;
    bit_d    = bit_q;
    txd_d    = txd_q;
    shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    last = (cnt_q == 16'd0);
    if (state_q != IDLE && !last) cnt_d = cnt_q - 16'd1;

    case (state_q)
      IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      START: begin
        if (last) begin
          state_d = DATA;
          cnt_d   = plat_q;
          bit_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (last) begin
          cnt_d = plat_q;
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = parity_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (last) begin
          state_d = STOP;
          cnt_d   = plat_q;
          txd_d   = 1'b1;
        end
      end
`endif
      STOP: begin
        // Popping on the final stop cycle keeps back-to-back frames gapless.
        if (last) begin
          if (count_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Bit period is latched here so prescale changes only affect later frames.
    if (pop) begin
      plat_d   = (prescale == 16'd0) ? 16'd0 : prescale - 16'd1;
      cnt_d    = plat_d;
      state_d  = START;
      txd_d    = 1'b0;
      shift_d  = mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      parity_d = ^mem[rd_ptr_q];
`endif
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    ovf_d   = tx_valid && !ready_q;
    busy_d  = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      plat_q   <= '0;
      bit_q    <= '0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      plat_q   <= plat_d;
      bit_q    <= bit_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= tx_data;
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
  end

  assign tx_ready       = ready_q;
  assign txd            = txd_q;
  assign busy           = busy_q;
  assign fifo_count     = count_q;
  assign overflow_error = ovf_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted bytes are queued, a line decoder pops and checks frames.
module tb_uart_tx;
  localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int WAIT_LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] prescale = 16'd16;
  logic [7:0]  tx_data = 8'd0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, txd, busy, overflow_error;
  logic [2:0]  fifo_count;

  uart_tx #(.DATA_WIDTH(8), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .prescale(prescale), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .txd(txd), .busy(busy), .fifo_count(fifo_count),
    .overflow_error(overflow_error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc_no = 0;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] b);
    logic [NBITS-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  logic [7:0]       exp_q[$];
  int               exp_ov = 0;
  int               ov_seen = 0;
  int               frames_done = 0;
  bit               mon_active = 1'b0;
  bit               mon_bad;
  int               mon_bit, mon_cyc, mon_p;
  int               p_prev = 16;
  logic [NBITS-1:0] mon_exp;

  // Line decoder: every clock of every bit must carry the expected level.
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && txd == 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_start", 1, 0);
        end else begin
          mon_exp    = frame_bits(exp_q.pop_front());
          mon_active = 1'b1;
          mon_bit    = 0;
          mon_cyc    = 0;
          mon_bad    = 1'b0;
          mon_p      = p_prev;
        end
      end
      if (mon_active) begin
        if (txd !== mon_exp[mon_bit]) mon_bad = 1'b1;
        mon_cyc++;
        if (mon_cyc == mon_p) begin
          check($sformatf("frame_bit%0d", mon_bit),
                mon_bad ? !mon_exp[mon_bit] : mon_exp[mon_bit], mon_exp[mon_bit]);
          mon_bit++;
          mon_cyc = 0;
          mon_bad = 1'b0;
          if (mon_bit == NBITS) begin
            mon_active = 1'b0;
            frames_done++;
          end
        end
      end
      if (overflow_error) ov_seen++;
    end
    p_prev = (prescale == 16'd0) ? 1 : int'(prescale);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit acc);
    tx_valid = 1'b1;
    tx_data  = b;
    acc      = tx_ready;
    if (acc) exp_q.push_back(b);
    else     exp_ov++;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int unsigned t0, input int exp_len, input string name);
    int n = 0;
    while ((busy || mon_active) && n < WAIT_LIMIT) begin
      cyc(1);
      n++;
    end
    check({name, "_timeout"}, n < WAIT_LIMIT, 1);
    if (exp_len >= 0) check({name, "_len"}, cyc_no - t0, exp_len);
    check({name, "_queue_drained"}, exp_q.size(), 0);
    check({name, "_overflows"}, ov_seen, exp_ov);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned t0;
    bit          acc;
    int          peak, first_rej, rejects, fd;
    logic [7:0]  burst [4];
    burst = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    cyc(3);
    check("rst_txd", txd, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow_error, 0);
    rst = 1'b0;
    cyc(2);

    // Single byte at 115200-style prescale.
    prescale = 16'd868;
    cyc(2);
    t0 = cyc_no;
    send_byte(8'hA5, acc);
    check("single_txd_before_start", txd, 1);
    cyc(1);
    check("single_txd_start", txd, 0);
    wait_done(t0, 2 + NBITS * 868, "single");

    // Burst of four bytes on consecutive cycles.
    prescale = 16'd16;
    cyc(2);
    t0 = cyc_no;
    peak = 0;
    foreach (burst[i]) begin
      send_byte(burst[i], acc);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    check("burst_peak_count", peak, 3);
    wait_done(t0, 2 + 4 * NBITS * 16, "burst");

    // Overflow: six writes into a four-deep FIFO.
    prescale = 16'd8;
    cyc(2);
    t0 = cyc_no;
    fd = frames_done;
    first_rej = -1;
    rejects = 0;
    for (int i = 1; i <= 6; i++) begin
      send_byte(8'(i), acc);
      if (!acc) begin
        rejects++;
        if (first_rej < 0) first_rej = i - 1;
      end
    end
    check("ovf_first_reject_idx", first_rej, 5);
    check("ovf_reject_count", rejects, 1);
    wait_done(t0, 2 + 5 * NBITS * 8, "ovf");
    check("ovf_frames_sent", frames_done - fd, 5);

    // Long bit period with prescale changed mid-frame.
    prescale = 16'd1041;
    cyc(2);
    t0 = cyc_no;
    send_byte(8'h5A, acc);
    cyc(100);
    prescale = 16'd5;
    wait_done(t0, 2 + NBITS * 1041, "slow");

    // Reset during DATA bit 3 with two bytes queued.
    prescale = 16'd20;
    cyc(2);
    t0 = cyc_no;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), acc);
    while (cyc_no < t0 + 2 + 4 * 20 + 5) cyc(1);
    check("rstmid_pre_count", fifo_count, 2);
    rst = 1'b1;
    exp_q.delete();
    cyc(1);
    rst = 1'b0;
    check("rstmid_txd", txd, 1);
    check("rstmid_fifo_count", fifo_count, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_tx_ready", tx_ready, 1);
    fd = frames_done;
    cyc(300);
    check("rstmid_no_frames", frames_done - fd, 0);
    check("rstmid_txd_idle", txd, 1);

    // Prescale zero behaves as one clock per bit.
    prescale = 16'd0;
    cyc(2);
    t0 = cyc_no;
    send_byte(8'h81, acc);
    wait_done(t0, 2 + NBITS, "p0");

    // Randomized traffic with random bit periods and valid gaps.
    for (int it = 0; it < 40; it++) begin
      prescale = 16'($urandom_range(0, 9));
      cyc(2);
      for (int k = 0; k < int'($urandom_range(1, 8)); k++) begin
        if ($urandom_range(0, 3) != 0) send_byte(8'($urandom), acc);
        else cyc(1);
      end
      wait_done(0, -1, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
